icache_responder: RTL and testbench

- Direct-mapped instruction cache. It is the responder side of the fetch unit's icache request/response handshake.
- Accepts one word-fetch request at a time and returns the instruction word together with the echoed request address.
- On a miss, refills a whole line from the memory port, one word per beat.
- Sits between the fetch stage and the instruction memory / bus bridge.

---
 rtl/icache_responder.sv | 136 +++++++++++++
 tb/tb_icache_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/icache_responder.sv
// icache_responder: direct-mapped instruction cache serving one fetch at a time;
// misses refill the whole line from memory, one ascending word per beat.
module icache_responder #(
    parameter int LINES          = 16,
    parameter int INDEX_WIDTH    = 4,
    parameter int WORDS_PER_LINE = 4,
    parameter int OFFSET_WIDTH   = 2,
    parameter int TAG_WIDTH      = 32 - INDEX_WIDTH - OFFSET_WIDTH - 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        icache_req_valid,
    output logic        icache_req_ready,
    input  logic [31:0] fetch_address,
    output logic        icache_resp_valid,
    input  logic        icache_resp_ready,
    output logic [31:0] fetch_data,
    output logic [31:0] icache_resp_address,
    input  logic        invalidate,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);
    typedef enum logic [2:0] {IDLE, LOOKUP, MEM_REQ, REFILL, RESP} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             req_addr_q, req_addr_d;
    logic [31:0]             fetch_data_q, fetch_data_d;
    logic [31:0]             mem_addr_q, mem_addr_d;
    logic [OFFSET_WIDTH-1:0] beat_q, beat_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic                    inv_pend_q, inv_pend_d;

    logic [TAG_WIDTH-1:0]    tag_mem  [LINES];
    logic [31:0]             data_mem [LINES][WORDS_PER_LINE];

    logic [OFFSET_WIDTH-1:0] offset;
    logic [INDEX_WIDTH-1:0]  index;
    logic [TAG_WIDTH-1:0]    tag;
    logic                    hit;
    logic                    last_beat;
    logic                    beat_fire;

    assign offset    = req_addr_q[OFFSET_WIDTH+1:2];
    assign index     = req_addr_q[OFFSET_WIDTH+2 +: INDEX_WIDTH];
    assign tag       = req_addr_q[31 -: TAG_WIDTH];
    assign hit       = valid_q[index] && (tag_mem[index] == tag);
    assign last_beat = beat_q == OFFSET_WIDTH'(WORDS_PER_LINE - 1);
    assign beat_fire = (state_q == REFILL) && mem_resp_valid;

    // A live or pending invalidate blocks acceptance so the flush lands before the next lookup.
    assign icache_req_ready    = (state_q == IDLE) && !inv_pend_q && !invalidate;
    assign icache_resp_valid   = state_q == RESP;
    assign fetch_data          = fetch_data_q;
    assign icache_resp_address = req_addr_q;
    assign mem_req_valid       = state_q == MEM_REQ;
    assign mem_req_addr        = mem_addr_q;

    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        fetch_data_d = fetch_data_q;
        mem_addr_d   = mem_addr_q;
        beat_d       = beat_q;
        valid_d      = valid_q;
        inv_pend_d   = inv_pend_q || (invalidate && state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (inv_pend_q || invalidate) begin
                    valid_d    = '0;
                    inv_pend_d = 1'b0;
                end else if (icache_req_valid) begin
                    req_addr_d = fetch_address;
                    state_d    = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    fetch_data_d = data_mem[index][offset];
                    state_d      = RESP;
                end else begin
                    mem_addr_d = {req_addr_q[31:OFFSET_WIDTH+2], {(OFFSET_WIDTH+2){1'b0}}};
                    state_d    = MEM_REQ;
                end
            end
            MEM_REQ: begin
                if (mem_req_ready) begin
                    beat_d  = '0;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (mem_resp_valid) begin
                    beat_d       = beat_q + 1'b1;
                    fetch_data_d = (beat_q == offset) ? mem_resp_data : fetch_data_q;
                    if (last_beat) begin
                        valid_d[index] = 1'b1;
                        state_d        = RESP;
                    end
                end
            end
            RESP: state_d = icache_resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            req_addr_q   <= '0;
            fetch_data_q <= '0;
            mem_addr_q   <= '0;
            beat_q       <= '0;
            valid_q      <= '0;
            inv_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            fetch_data_q <= fetch_data_d;
            mem_addr_q   <= mem_addr_d;
            beat_q       <= beat_d;
            valid_q      <= valid_d;
            inv_pend_q   <= inv_pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && beat_fire) begin
            data_mem[index][beat_q] <= mem_resp_data;
            if (last_beat)
                tag_mem[index] <= tag;
        end
    end
endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: directed checks of hit/miss, refill, backpressure, invalidate and reset.
module tb_icache_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        icache_req_valid = 1'b0;
    logic        icache_req_ready;
    logic [31:0] fetch_address = '0;
    logic        icache_resp_valid;
    logic        icache_resp_ready = 1'b0;
    logic [31:0] fetch_data;
    logic [31:0] icache_resp_address;
    logic        invalidate = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;

    int checks = 0;
    int errors = 0;

    icache_responder dut (
        .clk(clk), .reset(reset),
        .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
        .fetch_address(fetch_address),
        .icache_resp_valid(icache_resp_valid), .icache_resp_ready(icache_resp_ready),
        .fetch_data(fetch_data), .icache_resp_address(icache_resp_address),
        .invalidate(invalidate),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", t, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [31:0] a);
        int n = 0;
        icache_req_valid = 1'b1;
        fetch_address    = a;
        @(negedge clk);
        while (!icache_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready", 32'(icache_req_ready), 32'd1);
        tick();
        icache_req_valid = 1'b0;
    endtask

    // Answers the refill with words base*(i+1); optional invalidate or reset on a given beat.
    task automatic serve_refill(input logic [31:0] exp_addr, input logic [31:0] base,
                                input int inv_beat, input int rst_beat);
        int n = 0;
        while (!mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk("mem_req_valid", 32'(mem_req_valid), 32'd1);
        chk("mem_req_addr", mem_req_addr, exp_addr);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = base * 32'(i + 1);
            invalidate     = (i == inv_beat);
            reset          = (i == rst_beat);
            tick();
            invalidate = 1'b0;
            if (i == rst_beat) begin
                reset = 1'b0;
                mem_resp_valid = 1'b0;
                chk("rst_resp_valid", 32'(icache_resp_valid), 32'd0);
                chk("rst_req_ready", 32'(icache_req_ready), 32'd1);
                mem_resp_valid = 1'b1;
                mem_resp_data  = base * 32'(i + 2);
                tick();
                mem_resp_valid = 1'b0;
                chk("stray_resp_valid", 32'(icache_resp_valid), 32'd0);
                chk("stray_mem_req", 32'(mem_req_valid), 32'd0);
                return;
            end
        end
        mem_resp_valid = 1'b0;
    endtask

    task automatic take_resp(input logic [31:0] exp_data, input logic [31:0] exp_addr);
        chk("resp_valid", 32'(icache_resp_valid), 32'd1);
        chk("fetch_data", fetch_data, exp_data);
        chk("resp_addr", icache_resp_address, exp_addr);
        chk("resp_req_ready", 32'(icache_req_ready), 32'd0);
        icache_resp_ready = 1'b1;
        tick();
        icache_resp_ready = 1'b0;
        chk("resp_done", 32'(icache_resp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_req_ready", 32'(icache_req_ready), 32'd1);
        chk("rst_resp_valid", 32'(icache_resp_valid), 32'd0);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_fetch_data", fetch_data, 32'h0);
        chk("rst_resp_addr", icache_resp_address, 32'h0);
        chk("rst_mem_req_addr", mem_req_addr, 32'h0);

        // Cold miss
        send_req(32'h8000_0008);
        serve_refill(32'h8000_0000, 32'h11, -1, -1);
        take_resp(32'h33, 32'h8000_0008);

        // Hit: response in the second cycle after the request cycle, no memory traffic
        send_req(32'h8000_000C);
        chk("hit_lookup_mem_req", 32'(mem_req_valid), 32'd0);
        chk("hit_lookup_resp", 32'(icache_resp_valid), 32'd0);
        tick();
        chk("hit_mem_req", 32'(mem_req_valid), 32'd0);
        take_resp(32'h44, 32'h8000_000C);

        // Conflict miss with response backpressure
        send_req(32'h8000_0100);
        serve_refill(32'h8000_0100, 32'h0101_0101, -1, -1);
        for (int c = 0; c < 5; c++) begin
            chk("bp_resp_valid", 32'(icache_resp_valid), 32'd1);
            chk("bp_data", fetch_data, 32'h0101_0101);
            chk("bp_addr", icache_resp_address, 32'h8000_0100);
            chk("bp_req_ready", 32'(icache_req_ready), 32'd0);
            tick();
        end
        take_resp(32'h0101_0101, 32'h8000_0100);

        // Evicted line misses again
        send_req(32'h8000_0004);
        serve_refill(32'h8000_0000, 32'h11, -1, -1);
        take_resp(32'h22, 32'h8000_0004);

        // Invalidate during refill: response intact, flush applied on return to idle
        send_req(32'h8000_0048);
        serve_refill(32'h8000_0040, 32'h100, 1, -1);
        take_resp(32'h300, 32'h8000_0048);
        chk("pend_req_ready", 32'(icache_req_ready), 32'd0);
        send_req(32'h8000_0048);
        serve_refill(32'h8000_0040, 32'h1000, -1, -1);
        take_resp(32'h3000, 32'h8000_0048);

        // Invalidate in idle blocks the concurrent request for one cycle
        icache_req_valid = 1'b1;
        fetch_address    = 32'h8000_0044;
        invalidate       = 1'b1;
        @(negedge clk);
        chk("inv_idle_req_ready", 32'(icache_req_ready), 32'd0);
        tick();
        invalidate = 1'b0;
        chk("inv_idle_state", 32'(icache_resp_valid | mem_req_valid), 32'd0);
        send_req(32'h8000_0044);
        serve_refill(32'h8000_0040, 32'h10000, -1, -1);
        take_resp(32'h20000, 32'h8000_0044);

        // Reset during beat 2 of a refill
        send_req(32'h8000_0208);
        serve_refill(32'h8000_0200, 32'h7, -1, 2);
        send_req(32'h8000_0208);
        serve_refill(32'h8000_0200, 32'h9, -1, -1);
        take_resp(32'h1B, 32'h8000_0208);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
